// File: rtl/return_stack_if.sv
// Return-stack bus: CALL/RET controls and PC value from the core, top-of-stack
// address and occupancy/error status back to the core.
interface return_stack_if #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4
);
  localparam int unsigned CountWidth = $clog2(Depth + 1);

  logic                  push;
  logic                  pop;
  logic [DataWidth-1:0]  din;
  logic [DataWidth-1:0]  dout;
  logic [CountWidth-1:0] count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, din,
    input  dout, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, din,
    output dout, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// LIFO of return addresses (PC + WordByteSize) feeding the program counter load path.
// Define RETURN_STACK_WRAP_EN for circular storage where a push while full overwrites the oldest.
module return_stack #(
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned Depth        = 4,
  parameter int unsigned WordByteSize = 1
) (
  input logic            clk,
  input logic            reset,
  return_stack_if.slave  bus
);
  localparam int unsigned CountWidth = $clog2(Depth + 1);
  localparam int unsigned PtrWidth   = $clog2(Depth);

  typedef logic [PtrWidth-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic ptr_t ptr_dec(input ptr_t p);
    return (p == '0) ? PtrWidth'(Depth - 1) : p - 1'b1;
  endfunction

  logic [DataWidth-1:0]  mem_q [Depth];
  logic [CountWidth-1:0] count_q, count_d;
  ptr_t                  head_q, head_d;   // slot the next push writes
  logic [DataWidth-1:0]  dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  mem_we;
  ptr_t                  mem_waddr;
  logic [DataWidth-1:0]  ret_addr;
  ptr_t                  top_ptr;
  ptr_t                  below_ptr;
  logic                  is_empty;
  logic                  is_full;

  assign ret_addr  = bus.din + DataWidth'(WordByteSize);
  assign top_ptr   = ptr_dec(head_q);
  assign below_ptr = ptr_dec(top_ptr);
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CountWidth'(Depth));

  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = head_q;

    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (!is_full) begin
          mem_we  = 1'b1;
          head_d  = ptr_inc(head_q);
          count_d = count_q + 1'b1;
          dout_d  = ret_addr;
        end else begin
`ifdef RETURN_STACK_WRAP_EN
          // When full, head points at the oldest entry, so a plain push overwrites it.
          mem_we = 1'b1;
          head_d = ptr_inc(head_q);
          dout_d = ret_addr;
`else
          overflow_d = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          head_d  = top_ptr;
          count_d = count_q - 1'b1;
          dout_d  = (count_q == CountWidth'(1)) ? '0 : mem_q[below_ptr];
        end
      end
      2'b11: begin
        if (is_empty) begin
          mem_we  = 1'b1;
          head_d  = ptr_inc(head_q);
          count_d = CountWidth'(1);
          dout_d  = ret_addr;
        end else begin
          // Tail call: replace the top entry in place, allowed even when full.
          mem_we    = 1'b1;
          mem_waddr = top_ptr;
          dout_d    = ret_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      head_q      <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage carries no reset; contents are meaningless once count drops.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= ret_addr;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: stimulus queues expected post-edge state,
// an independent monitor pops and compares it after each active edge.
module tb_return_stack;
  localparam int unsigned DataWidth = 8;
  localparam int unsigned Depth     = 4;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  return_stack_if #(.DataWidth(DataWidth), .Depth(Depth)) bus ();

  return_stack #(
    .DataWidth   (DataWidth),
    .Depth       (Depth),
    .WordByteSize(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Drive one cycle of stimulus and queue the state expected after its edge.
  task automatic step(input string name, input logic r, input logic pu, input logic po,
                      input logic [7:0] d, input logic [7:0] e_dout, input logic [2:0] e_cnt,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clk);
    reset    = r;
    bus.push = pu;
    bus.pop  = po;
    bus.din  = d;
    e.name  = name;
    e.dout  = e_dout;
    e.count = e_cnt;
    e.empty = (e_cnt == 3'd0);
    e.full  = (e_cnt == 3'd4);
    e.ovf   = e_ovf;
    e.unf   = e_unf;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.dout === e.dout && bus.count === e.count && bus.empty === e.empty &&
            bus.full === e.full && bus.overflow === e.ovf && bus.underflow === e.unf) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                   e.name, bus.dout, bus.count, bus.empty, bus.full, bus.overflow,
                   bus.underflow, e.dout, e.count, e.empty, e.full, e.ovf, e.unf);
        end
      end
    end
  end

  initial begin : stimulus
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;

    // 1: reset wins over push+pop
    step("rst_push_pop", 1, 1, 1, 8'h55, 8'h00, 3'd0, 0, 0);

    // 2: push 10,20,30 then pop x3
    step("push10", 0, 1, 0, 8'h10, 8'h11, 3'd1, 0, 0);
    step("push20", 0, 1, 0, 8'h20, 8'h21, 3'd2, 0, 0);
    step("push30", 0, 1, 0, 8'h30, 8'h31, 3'd3, 0, 0);
    step("pop_a",  0, 0, 1, 8'h00, 8'h21, 3'd2, 0, 0);
    step("pop_b",  0, 0, 1, 8'h00, 8'h11, 3'd1, 0, 0);
    step("pop_c",  0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0);

    // 3: tail call with one entry
    step("push10_t", 0, 1, 0, 8'h10, 8'h11, 3'd1, 0, 0);
    step("tail40",   0, 1, 1, 8'h40, 8'h41, 3'd1, 0, 0);
    step("pop_t",    0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0);

    // 4: fill, tail call while full, then push while full
    step("push01", 0, 1, 0, 8'h01, 8'h02, 3'd1, 0, 0);
    step("push02", 0, 1, 0, 8'h02, 8'h03, 3'd2, 0, 0);
    step("push03", 0, 1, 0, 8'h03, 8'h04, 3'd3, 0, 0);
    step("push04", 0, 1, 0, 8'h04, 8'h05, 3'd4, 0, 0);
    step("tail_full", 0, 1, 1, 8'h50, 8'h51, 3'd4, 0, 0);
`ifdef RETURN_STACK_WRAP_EN
    step("push_full", 0, 1, 0, 8'h05, 8'h06, 3'd4, 0, 0);
    step("wpop1", 0, 0, 1, 8'h00, 8'h51, 3'd3, 0, 0);
    step("wpop2", 0, 0, 1, 8'h00, 8'h04, 3'd2, 0, 0);
    step("wpop3", 0, 0, 1, 8'h00, 8'h03, 3'd1, 0, 0);
    step("wpop4", 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0);
`else
    step("push_full", 0, 1, 0, 8'h05, 8'h51, 3'd4, 1, 0);
    step("opop1", 0, 0, 1, 8'h00, 8'h04, 3'd3, 1, 0);
    step("opop2", 0, 0, 1, 8'h00, 8'h03, 3'd2, 1, 0);
    step("opop3", 0, 0, 1, 8'h00, 8'h02, 3'd1, 1, 0);
    step("opop4", 0, 0, 1, 8'h00, 8'h00, 3'd0, 1, 0);
`endif
    step("rst_4", 1, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);

    // 5: push+pop on empty is a plain push; underflow is sticky
    step("tail_empty", 0, 1, 1, 8'h09, 8'h0a, 3'd1, 0, 0);
    step("pop_5",      0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0);
    step("pop_empty",  0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 1);
    step("push07",     0, 1, 0, 8'h07, 8'h08, 3'd1, 0, 1);
    step("idle",       0, 0, 0, 8'hee, 8'h08, 3'd1, 0, 1);
    step("rst_5",      1, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);

    // 6: PC wraps to zero; reset mid-operation
    step("pushFF",  0, 1, 0, 8'hff, 8'h00, 3'd1, 0, 0);
    step("push10_6", 0, 1, 0, 8'h10, 8'h11, 3'd2, 0, 0);
    step("push20_6", 0, 1, 0, 8'h20, 8'h21, 3'd3, 0, 0);
    step("rst_6",   1, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
    step("pop_after_rst", 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 1);

    @(negedge clk);
    reset    = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
